// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-wide synchronous RAM port between the
// instruction-fetch requester (IF) and the data-access requester (MEM).
// A granted access is sequenced as 1, 2 or 4 single-byte RAM cycles.
// Read bytes are assembled little-endian into a 32-bit result, and a
// one-cycle done pulse goes to the port that owned the access.
// Every output is driven from a register.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_FIRST  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic [31:0]           if_data,
    output logic                  if_done,
    input  logic                  mem_req,
    input  logic                  mem_we,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [1:0]            mem_len,
    input  logic [31:0]           mem_wdata,
    output logic [31:0]           mem_rdata,
    output logic                  mem_done,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_we,
    output logic [7:0]            ram_wdata,
    input  logic [7:0]            ram_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_FLUSH  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Selects byte idx of a little-endian word.
    function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        return b;
    endfunction

    // Replaces byte idx of a little-endian word.
    function automatic logic [31:0] byte_insert(input logic [31:0] w, input logic [1:0] idx,
                                                input logic [7:0] b);
        logic [31:0] r;
        r = w;
        case (idx)
            2'd0:    r[7:0]   = b;
            2'd1:    r[15:8]  = b;
            2'd2:    r[23:16] = b;
            default: r[31:24] = b;
        endcase
        return r;
    endfunction

    // Index of the last byte of an access. Length code 3 is handled as a word.
    function automatic logic [1:0] len_last(input logic [1:0] len);
        logic [1:0] l;
        case (len)
            2'd0:    l = 2'd0;
            2'd1:    l = 2'd1;
            default: l = 2'd3;
        endcase
        return l;
    endfunction

    state_t                state_r, state_s;
    logic [1:0]            cnt_r;
    logic [1:0]            last_r;
    logic                  owner_r;       // 1 = MEM owns the current access
    logic                  we_r;
    logic [ADDR_WIDTH-1:0] base_r;
    logic [31:0]           wdata_r;
    logic [31:0]           rbuf_r;

    logic                  grant_mem_s, grant_if_s, abort_s;
    logic [ADDR_WIDTH-1:0] acc_base_s;
    logic [1:0]            acc_cnt_s;
    logic                  acc_we_s;
    logic [31:0]           acc_wdata_s;
    logic [31:0]           final_s;

    logic [ADDR_WIDTH-1:0] ram_addr_r, ram_addr_s;
    logic                  ram_we_r, ram_we_s;
    logic [7:0]            ram_wdata_r, ram_wdata_s;
    logic [31:0]           if_data_r, if_data_s;
    logic [31:0]           mem_rdata_r, mem_rdata_s;
    logic                  if_done_r, if_done_s;
    logic                  mem_done_r, mem_done_s;

    // Grant decision in IDLE, and the IF abort condition.
    always_comb begin
        grant_mem_s = 1'b0;
        grant_if_s  = 1'b0;
        if (state_r == ST_IDLE) begin
            if (MEM_FIRST != 0) begin
                grant_mem_s = mem_req;
                grant_if_s  = if_req & ~mem_req;
            end else begin
                grant_if_s  = if_req;
                grant_mem_s = mem_req & ~if_req;
            end
        end else begin
            grant_mem_s = 1'b0;
            grant_if_s  = 1'b0;
        end
        abort_s = ((state_r == ST_ACCESS) || (state_r == ST_FLUSH)) & ~owner_r & ~if_req;
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_mem_s || grant_if_s) begin
                    state_s = ST_ACCESS;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (abort_s) begin
                    state_s = ST_IDLE;
                end else if (cnt_r == last_r) begin
                    state_s = we_r ? ST_DONE : ST_FLUSH;
                end else begin
                    state_s = ST_ACCESS;
                end
            end
            ST_FLUSH: begin
                if (abort_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Latches the winner's request and steps the byte counter and read buffer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r   <= 2'd0;
            last_r  <= 2'd0;
            owner_r <= 1'b0;
            we_r    <= 1'b0;
            base_r  <= {ADDR_WIDTH{1'b0}};
            wdata_r <= 32'h0000_0000;
            rbuf_r  <= 32'h0000_0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_mem_s) begin
                        owner_r <= 1'b1;
                        base_r  <= mem_addr;
                        we_r    <= mem_we;
                        wdata_r <= mem_wdata;
                        last_r  <= len_last(mem_len);
                        cnt_r   <= 2'd0;
                        rbuf_r  <= 32'h0000_0000;
                    end else if (grant_if_s) begin
                        owner_r <= 1'b0;
                        base_r  <= if_addr;
                        we_r    <= 1'b0;
                        wdata_r <= 32'h0000_0000;
                        last_r  <= 2'd3;
                        cnt_r   <= 2'd0;
                        rbuf_r  <= 32'h0000_0000;
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                ST_ACCESS: begin
                    cnt_r <= cnt_r + 2'd1;
                    // The RAM returns a byte one cycle after its address.
                    if (!we_r && (cnt_r != 2'd0)) begin
                        rbuf_r <= byte_insert(rbuf_r, cnt_r - 2'd1, ram_rdata);
                    end else begin
                        rbuf_r <= rbuf_r;
                    end
                end
                ST_FLUSH: rbuf_r <= byte_insert(rbuf_r, last_r, ram_rdata);
                default:  cnt_r  <= cnt_r;
            endcase
        end
    end

    // Computes the next values of the registered outputs from the upcoming state.
    always_comb begin
        ram_addr_s  = {ADDR_WIDTH{1'b0}};
        ram_we_s    = 1'b0;
        ram_wdata_s = 8'h00;
        if_done_s   = 1'b0;
        mem_done_s  = 1'b0;
        if_data_s   = if_data_r;
        mem_rdata_s = mem_rdata_r;
        final_s     = byte_insert(rbuf_r, last_r, ram_rdata);

        // Describes the byte cycle being entered: the first one comes from the
        // winner's inputs, the later ones from the latched request.
        if (state_r == ST_IDLE) begin
            if (grant_mem_s) begin
                acc_base_s  = mem_addr;
                acc_we_s    = mem_we;
                acc_wdata_s = mem_wdata;
            end else begin
                acc_base_s  = if_addr;
                acc_we_s    = 1'b0;
                acc_wdata_s = 32'h0000_0000;
            end
            acc_cnt_s = 2'd0;
        end else begin
            acc_base_s  = base_r;
            acc_cnt_s   = cnt_r + 2'd1;
            acc_we_s    = we_r;
            acc_wdata_s = wdata_r;
        end

        case (state_s)
            ST_ACCESS: begin
                ram_addr_s  = acc_base_s + {{(ADDR_WIDTH-2){1'b0}}, acc_cnt_s};
                ram_we_s    = acc_we_s;
                ram_wdata_s = acc_we_s ? byte_sel(acc_wdata_s, acc_cnt_s) : 8'h00;
            end
            ST_DONE: begin
                if (owner_r) begin
                    mem_done_s = 1'b1;
                end else begin
                    if_done_s = 1'b1;
                end
                // Only reads pass through FLUSH, so only they update data.
                if (state_r == ST_FLUSH) begin
                    if (owner_r) begin
                        mem_rdata_s = final_s;
                    end else begin
                        if_data_s = final_s;
                    end
                end else begin
                    mem_rdata_s = mem_rdata_r;
                end
            end
            default: ram_we_s = 1'b0;
        endcase
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ram_addr_r  <= {ADDR_WIDTH{1'b0}};
            ram_we_r    <= 1'b0;
            ram_wdata_r <= 8'h00;
            if_data_r   <= 32'h0000_0000;
            mem_rdata_r <= 32'h0000_0000;
            if_done_r   <= 1'b0;
            mem_done_r  <= 1'b0;
        end else begin
            ram_addr_r  <= ram_addr_s;
            ram_we_r    <= ram_we_s;
            ram_wdata_r <= ram_wdata_s;
            if_data_r   <= if_data_s;
            mem_rdata_r <= mem_rdata_s;
            if_done_r   <= if_done_s;
            mem_done_r  <= mem_done_s;
        end
    end

    assign ram_addr  = ram_addr_r;
    assign ram_we    = ram_we_r;
    assign ram_wdata = ram_wdata_r;
    assign if_data   = if_data_r;
    assign mem_rdata = mem_rdata_r;
    assign if_done   = if_done_r;
    assign mem_done  = mem_done_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: byte RAM environment plus a reference memory
// model. Expected data, latencies and address sequences are derived from the
// access rules (N bytes, little-endian, read N+2 / write N+1 cycles).
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_data;
    logic        if_done;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [1:0]  mem_len;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_done;
    logic [31:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;

    int total = 0;
    int bad   = 0;

    // RAM environment (indexed by the low 16 address bits) and reference memory.
    logic [7:0]  ram     [0:65535];
    logic [7:0]  ref_mem [0:65535];
    logic [31:0] wr_addr_q [$];
    logic [7:0]  wr_data_q [$];
    logic [31:0] addr_q    [$];
    logic [31:0] last_if_exp;

    mem_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_data   (if_data),
        .if_done   (if_done),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_len   (mem_len),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_done  (mem_done),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous byte RAM: read data appears the cycle after its address.
    initial begin
        logic [7:0] rd_v;
        ram_rdata <= 8'h00;
        forever begin
            @(posedge clk);
            rd_v = ram[ram_addr[15:0]];
            if (ram_we === 1'b1) begin
                ram[ram_addr[15:0]] = ram_wdata;
                wr_addr_q.push_back(ram_addr);
                wr_data_q.push_back(ram_wdata);
            end
            ram_rdata <= rd_v;
        end
    end

    function automatic int len_n(input logic [1:0] len);
        if (len == 2'd0) return 1;
        else if (len == 2'd1) return 2;
        else return 4;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a, input int n);
        logic [31:0] r;
        logic [31:0] ai;
        r = 32'h0;
        for (int i = 0; i < n; i++) begin
            ai = a + 32'(i);
            r = r | ({24'h0, ref_mem[ai[15:0]]} << (8 * i));
        end
        return r;
    endfunction

    task automatic ref_write(input logic [31:0] a, input int n, input logic [31:0] wd);
        logic [31:0] ai;
        logic [31:0] w;
        w = wd;
        for (int i = 0; i < n; i++) begin
            ai = a + 32'(i);
            ref_mem[ai[15:0]] = w[7:0];
            w = w >> 8;
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [7:0] b);
        ram[a[15:0]]     = b;
        ref_mem[a[15:0]] = b;
    endtask

    // Runs one transaction and reports latency (0 = no done), data and whether
    // the other port's done fired. Leaves the DUT back in IDLE.
    task automatic drv(input logic is_mem, input logic we, input logic [31:0] addr,
                       input logic [1:0] len, input logic [31:0] wd,
                       output int lat, output logic [31:0] data, output logic other);
        lat = 0;
        data = 32'h0;
        other = 1'b0;
        addr_q.delete();
        if (is_mem) begin
            mem_req = 1'b1; mem_we = we; mem_addr = addr; mem_len = len; mem_wdata = wd;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            addr_q.push_back(ram_addr);
            if ((is_mem && if_done) || (!is_mem && mem_done)) other = 1'b1;
            if (is_mem ? mem_done : if_done) begin
                lat = c;
                data = is_mem ? mem_rdata : if_data;
                break;
            end
        end
        mem_req = 1'b0;
        if_req  = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        if_req = 1'b0; if_addr = 32'h0;
        mem_req = 1'b0; mem_we = 1'b0; mem_addr = 32'h0; mem_len = 2'd0; mem_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({if_data, if_done, mem_rdata, mem_done, ram_addr, ram_we, ram_wdata} !== 99'h0) begin
            $display("FAIL reset_outputs: got if_done=%b mem_done=%b ram_addr=%h ram_we=%b want all zero",
                     if_done, mem_done, ram_addr, ram_we);
            bad++;
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({if_data, if_done, mem_rdata, mem_done, ram_addr, ram_we, ram_wdata} !== 99'h0) begin
            $display("FAIL idle_outputs: got if_done=%b mem_done=%b ram_addr=%h ram_we=%b want all zero",
                     if_done, mem_done, ram_addr, ram_we);
            bad++;
        end
    endtask

    task automatic test_if_read;
        int lat; logic [31:0] d; logic oth;
        preload(32'h100, 8'h13); preload(32'h101, 8'h05);
        preload(32'h102, 8'h10); preload(32'h103, 8'h00);
        drv(1'b0, 1'b0, 32'h100, 2'd2, 32'h0, lat, d, oth);
        total++;
        if (lat !== 6) begin $display("FAIL if_read_latency: got %0d want 6", lat); bad++; end
        total++;
        if (d !== 32'h0010_0513) begin $display("FAIL if_read_data: got %h want 00100513", d); bad++; end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (addr_q.size() <= i || addr_q[i] !== 32'h100 + 32'(i)) begin
                $display("FAIL if_read_addr%0d: got %h want %h", i,
                         (addr_q.size() > i) ? addr_q[i] : 32'hDEAD_DEAD, 32'h100 + 32'(i));
                bad++;
            end
        end
        total++;
        if (oth !== 1'b0) begin $display("FAIL if_read_other_done: got %b want 0", oth); bad++; end
        last_if_exp = 32'h0010_0513;
    endtask

    task automatic test_mem_write;
        int lat; logic [31:0] d; logic oth;
        wr_addr_q.delete(); wr_data_q.delete();
        drv(1'b1, 1'b1, 32'h2000, 2'd1, 32'hAABB_CCDD, lat, d, oth);
        ref_write(32'h2000, 2, 32'hAABB_CCDD);
        total++;
        if (lat !== 3) begin $display("FAIL mem_write_latency: got %0d want 3", lat); bad++; end
        total++;
        if (wr_addr_q.size() !== 2) begin
            $display("FAIL mem_write_count: got %0d want 2", wr_addr_q.size()); bad++;
        end else begin
            total++;
            if (wr_addr_q[0] !== 32'h2000 || wr_data_q[0] !== 8'hDD) begin
                $display("FAIL mem_write_b0: got %h@%h want dd@00002000", wr_data_q[0], wr_addr_q[0]); bad++;
            end
            total++;
            if (wr_addr_q[1] !== 32'h2001 || wr_data_q[1] !== 8'hCC) begin
                $display("FAIL mem_write_b1: got %h@%h want cc@00002001", wr_data_q[1], wr_addr_q[1]); bad++;
            end
        end
    endtask

    task automatic test_priority;
        int md; int id; logic both; logic [31:0] mrd; logic [31:0] ifd; logic [31:0] exp_if;
        preload(32'h10, 8'h80);
        for (int i = 0; i < 4; i++) preload(32'h40 + 32'(i), 8'($urandom_range(0, 255)));
        exp_if = ref_read(32'h40, 4);
        md = 0; id = 0; both = 1'b0; mrd = 32'h0; ifd = 32'h0;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h10; mem_len = 2'd0;
        if_req = 1'b1; if_addr = 32'h40;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk); #1;
            if (mem_done && if_done) both = 1'b1;
            if (mem_done) begin md = c; mrd = mem_rdata; mem_req = 1'b0; end
            if (if_done) begin id = c; ifd = if_data; if_req = 1'b0; break; end
        end
        mem_req = 1'b0; if_req = 1'b0;
        @(posedge clk); #1;
        total++;
        if (md !== 3) begin $display("FAIL prio_mem_done_cycle: got %0d want 3", md); bad++; end
        total++;
        if (mrd !== 32'h0000_0080) begin $display("FAIL prio_mem_rdata: got %h want 00000080", mrd); bad++; end
        total++;
        if (id !== 10) begin $display("FAIL prio_if_done_cycle: got %0d want 10", id); bad++; end
        total++;
        if (ifd !== exp_if) begin $display("FAIL prio_if_data: got %h want %h", ifd, exp_if); bad++; end
        total++;
        if (both !== 1'b0) begin $display("FAIL prio_double_done: got %b want 0", both); bad++; end
        last_if_exp = exp_if;
    endtask

    task automatic test_wrap;
        int lat; logic [31:0] d; logic oth; logic [31:0] exp_d; logic [31:0] ea;
        for (int i = 0; i < 4; i++) begin
            ea = 32'hFFFF_FFFE + 32'(i);
            preload(ea, 8'($urandom_range(0, 255)));
        end
        exp_d = ref_read(32'hFFFF_FFFE, 4);
        drv(1'b0, 1'b0, 32'hFFFF_FFFE, 2'd2, 32'h0, lat, d, oth);
        for (int i = 0; i < 4; i++) begin
            ea = 32'hFFFF_FFFE + 32'(i);
            total++;
            if (addr_q.size() <= i || addr_q[i] !== ea) begin
                $display("FAIL wrap_addr%0d: got %h want %h", i,
                         (addr_q.size() > i) ? addr_q[i] : 32'hDEAD_DEAD, ea);
                bad++;
            end
        end
        total++;
        if (d !== exp_d || lat !== 6) begin
            $display("FAIL wrap_data: got %h lat %0d want %h lat 6", d, lat, exp_d); bad++;
        end
        last_if_exp = exp_d;
    endtask

    task automatic test_abort;
        logic saw_if; int md; logic [31:0] a3; logic [31:0] a4; logic [31:0] a5;
        logic [31:0] mrd; logic [31:0] exp_m;
        for (int i = 0; i < 4; i++) begin
            preload(32'h300 + 32'(i), 8'($urandom_range(0, 255)));
            preload(32'h400 + 32'(i), 8'($urandom_range(0, 255)));
        end
        exp_m = ref_read(32'h400, 4);
        saw_if = 1'b0; md = 0; a3 = 32'h0; a4 = 32'hFFFF_FFFF; a5 = 32'h0; mrd = 32'h0;
        if_req = 1'b1; if_addr = 32'h300;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (if_done) saw_if = 1'b1;
            if (c == 1) begin mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h400; mem_len = 2'd2; end
            if (c == 3) begin a3 = ram_addr; if_req = 1'b0; end
            if (c == 4) a4 = ram_addr;
            if (c == 5) a5 = ram_addr;
            if (mem_done) begin md = c; mrd = mem_rdata; mem_req = 1'b0; break; end
        end
        mem_req = 1'b0;
        @(posedge clk); #1;
        total++;
        if (a3 !== 32'h302) begin $display("FAIL abort_addr_cnt2: got %h want 00000302", a3); bad++; end
        total++;
        if (a4 !== 32'h0) begin $display("FAIL abort_idle_addr: got %h want 00000000", a4); bad++; end
        total++;
        if (a5 !== 32'h400) begin $display("FAIL abort_mem_grant_addr: got %h want 00000400", a5); bad++; end
        total++;
        if (md !== 10) begin $display("FAIL abort_mem_done_cycle: got %0d want 10", md); bad++; end
        total++;
        if (mrd !== exp_m) begin $display("FAIL abort_mem_rdata: got %h want %h", mrd, exp_m); bad++; end
        total++;
        if (saw_if !== 1'b0) begin $display("FAIL abort_if_done: got %b want 0", saw_if); bad++; end
        total++;
        if (if_data !== last_if_exp) begin
            $display("FAIL abort_if_data_hold: got %h want %h", if_data, last_if_exp); bad++;
        end
    endtask

    task automatic test_reset_mid;
        logic bad_after;
        for (int i = 0; i < 4; i++) preload(32'h500 + 32'(i), 8'h00);
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h500; mem_len = 2'd2; mem_wdata = 32'h1122_3344;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        total++;
        if ({if_data, if_done, mem_rdata, mem_done, ram_addr, ram_we, ram_wdata} !== 99'h0) begin
            $display("FAIL midreset_outputs: got ram_we=%b ram_addr=%h ram_wdata=%h want all zero",
                     ram_we, ram_addr, ram_wdata);
            bad++;
        end
        mem_req = 1'b0; mem_we = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        bad_after = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (mem_done || if_done || ram_we || ram_addr != 32'h0) bad_after = 1'b1;
        end
        total++;
        if (bad_after !== 1'b0) begin $display("FAIL midreset_after_release: got activity want idle"); bad++; end
        total++;
        if (ram[16'h0500] !== 8'h44 || ram[16'h0501] !== 8'h00) begin
            $display("FAIL midreset_partial_write: got %h %h want 44 00", ram[16'h0500], ram[16'h0501]); bad++;
        end
        ref_mem[16'h0500] = 8'h44;
        last_if_exp = 32'h0;
    endtask

    task automatic test_random;
        int lat; logic [31:0] d; logic oth; int kind; int n; int exp_lat;
        logic [31:0] a; logic [31:0] wd; logic [1:0] len; logic [31:0] exp_d; logic [31:0] w; logic ok;
        for (int i = 0; i < 264; i++) preload(32'h1000 + 32'(i), 8'($urandom_range(0, 255)));
        for (int t = 0; t < 30; t++) begin
            kind = $urandom_range(0, 2);
            a = 32'h1000 + 32'($urandom_range(0, 255));
            len = (kind == 0) ? 2'd2 : 2'($urandom_range(0, 3));
            wd = $urandom;
            n = len_n(len);
            wr_addr_q.delete(); wr_data_q.delete();
            if (kind == 2) begin
                drv(1'b1, 1'b1, a, len, wd, lat, d, oth);
                ref_write(a, n, wd);
                exp_lat = n + 1;
                ok = (wr_addr_q.size() == n);
                w = wd;
                for (int i = 0; i < n; i++) begin
                    if (ok && (wr_addr_q[i] !== a + 32'(i) || wr_data_q[i] !== w[7:0])) ok = 1'b0;
                    w = w >> 8;
                end
                total++;
                if (!ok) begin
                    $display("FAIL rand%0d_writes: got %0d writes want %0d bytes of %h at %h",
                             t, wr_addr_q.size(), n, wd, a);
                    bad++;
                end
            end else begin
                exp_d = ref_read(a, n);
                drv(kind == 1, 1'b0, a, len, 32'h0, lat, d, oth);
                exp_lat = n + 2;
                total++;
                if (d !== exp_d) begin $display("FAIL rand%0d_data: got %h want %h", t, d, exp_d); bad++; end
                total++;
                if (wr_addr_q.size() != 0) begin
                    $display("FAIL rand%0d_read_wrote: got %0d writes want 0", t, wr_addr_q.size()); bad++;
                end
            end
            total++;
            if (lat !== exp_lat) begin $display("FAIL rand%0d_latency: got %0d want %0d", t, lat, exp_lat); bad++; end
            total++;
            if (oth !== 1'b0) begin $display("FAIL rand%0d_other_done: got %b want 0", t, oth); bad++; end
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            ram[i] = 8'h00;
            ref_mem[i] = 8'h00;
        end
        last_if_exp = 32'h0;
        test_reset();
        test_if_read();
        test_mem_write();
        test_priority();
        test_wrap();
        test_abort();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one byte-wide synchronous RAM port between the instruction-fetch requester (IF) and the data-access requester (MEM stage).
- Arbitrates between the two requesters, then sequences each access as 1, 2 or 4 single-byte RAM cycles.
- Assembles read bytes little-endian into a 32-bit result and pulses a per-port done.
- Sits between the pipeline (reg_pc/IF and stage_mem) and the external RAM. Until done, the pipeline's stall logic holds the requesters.

Parameters:
- ADDR_WIDTH, 32, width of all address buses.
- MEM_FIRST, 1, 1 = MEM wins simultaneous requests; 0 = IF wins.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- if_req  in  1  fetch request; hold until if_done, or drop to abort.
- if_addr  in  ADDR_WIDTH  fetch byte address.
- if_data  out  32  fetched instruction; valid in the if_done cycle.
- if_done  out  1  one-cycle completion pulse for IF.
- mem_req  in  1  data request; hold with all fields stable until mem_done.
- mem_we  in  1  1 = write, 0 = read.
- mem_addr  in  ADDR_WIDTH  data byte address.
- mem_len  in  2  0 = 1 byte, 1 = 2 bytes, 2 = 4 bytes, 3 = treated as 4 bytes.
- mem_wdata  in  32  write data; low bytes used, little-endian.
- mem_rdata  out  32  read data, zero-extended, right-aligned; valid in the mem_done cycle.
- mem_done  out  1  one-cycle completion pulse for MEM.
- ram_addr  out  ADDR_WIDTH  RAM byte address.
- ram_we  out  1  RAM write strobe.
- ram_wdata  out  8  RAM write byte.
- ram_rdata  in  8  RAM read byte; valid the cycle after its address.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; cnt, owner and data registers cleared; every output is 0.
- States: IDLE, ACCESS, FLUSH, DONE. All outputs come from registers or from state only.
- IDLE:
  - At each edge, sample the requests. If MEM_FIRST=1, mem_req has priority; otherwise if_req has priority.
  - The winner's addr, len, we and wdata are latched, cnt=0, N = byte count, next state ACCESS.
  - IF requests always use N=4 with we=0.
  - With no request, stay in IDLE.
  - No preemption once ACCESS is entered.
- ACCESS, one byte per cycle:
  - ram_addr = base+cnt, computed modulo 2^ADDR_WIDTH (0xFFFFFFFF+1 wraps to 0).
  - ram_we = latched we. ram_wdata = wdata[8*cnt +: 8] when writing, else 0.
  - Reads: at the end of each ACCESS cycle with cnt≥1, capture ram_rdata into byte cnt-1.
  - After cnt=N-1: writes go to DONE; reads go to FLUSH.
- FLUSH: ram_we=0, ram_addr=0; capture ram_rdata into byte N-1; next state DONE.
- DONE:
  - Pulse the owner's done for exactly one cycle; the other done stays 0.
  - The read result shows on the owner's data output; unfilled upper bytes are 0.
  - Next state is IDLE.
  - Data outputs hold their value until that port's next completion.
- Latency, measured from the grant edge to the done cycle:
  - Read: N+2 cycles (word read: done in cycle 6).
  - Write: N+1 cycles (word write: done in cycle 5).
- Back-to-back requests: a requester sees done and updates req at the edge ending DONE. The following IDLE cycle therefore samples fresh requests, so no double grant occurs.
- IF abort: if if_req=0 during ACCESS or FLUSH of an IF transaction, return to IDLE at the next edge, with no if_done and if_data unchanged. Aborting does not affect MEM.
- MEM transactions cannot be aborted. Dropping mem_req early is a protocol violation; the block completes the access anyway.
- Outside ACCESS: ram_we=0, ram_wdata=0, ram_addr=0.
- Reset asserted mid-transaction: immediately return to IDLE with all outputs 0. A partial write is left in RAM.

Test Plan:
- Reset, then if_req=1, if_addr=0x100, RAM bytes 0x13,0x05,0x10,0x00 at 0x100..0x103 → ram_addr 0x100..0x103 in cycles 1-4; if_done in cycle 6; if_data=0x00100513.
- mem_req write, mem_len=1, addr=0x2000, wdata=0xAABBCCDD → ram_we=1 with bytes 0xDD@0x2000 and 0xCC@0x2001; mem_done in cycle 3; no other RAM writes.
- if_req and mem_req rise on the same edge, MEM_FIRST=1, mem byte read of 0x80 at 0x10 → mem_done first with mem_rdata=0x00000080; IF granted at the IDLE after DONE; if_done 6 cycles later.
- IF word read at 0xFFFFFFFE → ram_addr sequence 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000, 0x00000001.
- IF read with if_req dropped in ACCESS cnt=2 → next cycle IDLE; if_done never asserts; a pending mem_req is granted at the following edge.
- rst driven low in ACCESS during a word write → all outputs 0 asynchronously; after release, state IDLE; no done pulse.
